tcam_lookup_arbiter: RTL and testbench

- Shares one TCAM filter lookup port (tag/opcode/NID in, 4-bit flag out) between NUM_REQ requesters with round-robin arbitration.
- One lookup in flight at a time.
- Holds TCAM inputs stable for the TCAM's fixed latency, captures the flag, and returns it to the winning requester over a valid/ready response.
- Keeps a saturating hit counter for the filter.

---
 rtl/tcam_lookup_arbiter_if.sv | 38 +++
 rtl/tcam_lookup_arbiter.sv | 125 ++++++++++++
 tb/tb_tcam_lookup_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcam_lookup_arbiter_if.sv
// Requester, TCAM and response signals of the shared TCAM lookup port.
// master = requesters/TCAM side, slave = arbiter.
`timescale 1ns/1ps
interface tcam_lookup_arbiter_if #(
    parameter int WIDTH   = 33,
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_tag;
    logic [NUM_REQ*7-1:0]     req_opcode;
    logic [NUM_REQ*7-1:0]     req_nid;
    logic [WIDTH-1:0]         tcam_tag;
    logic [6:0]               tcam_opcode;
    logic [6:0]               tcam_nid;
    logic [3:0]               tcam_flag;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [3:0]               rsp_flag;
    logic                     busy;
    logic [CNT_W-1:0]         hit_cnt;

    modport master (
        output req_valid, req_tag, req_opcode, req_nid, tcam_flag, rsp_ready,
        input  req_ready, tcam_tag, tcam_opcode, tcam_nid,
        input  rsp_valid, rsp_id, rsp_flag, busy, hit_cnt
    );

    modport slave (
        input  req_valid, req_tag, req_opcode, req_nid, tcam_flag, rsp_ready,
        output req_ready, tcam_tag, tcam_opcode, tcam_nid,
        output rsp_valid, rsp_id, rsp_flag, busy, hit_cnt
    );
endinterface

// File: rtl/tcam_lookup_arbiter.sv
// Round-robin arbiter sharing one fixed-latency TCAM lookup port between
// NUM_REQ requesters, one lookup in flight, with a saturating hit counter.
`timescale 1ns/1ps
module tcam_lookup_arbiter #(
    parameter int WIDTH      = 33,
    parameter int NUM_REQ    = 4,
    parameter int LOOKUP_LAT = 1,
    parameter int CNT_W      = 16
) (
    input logic                  clk,
    input logic                  reset,
    tcam_lookup_arbiter_if.slave bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LAT_W = $clog2(LOOKUP_LAT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, RESP = 2'd2} state_t;

    state_t           state_reg;
    logic [ID_W-1:0]  rr_ptr_reg;
    logic [ID_W-1:0]  id_reg;
    logic [LAT_W-1:0] lat_cnt_reg;
    logic [WIDTH-1:0] tcam_tag_reg;
    logic [6:0]       tcam_opcode_reg;
    logic [6:0]       tcam_nid_reg;
    logic             rsp_valid_reg;
    logic [3:0]       rsp_flag_reg;
    logic [CNT_W-1:0] hit_cnt_reg;

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand_idx;
    int               cand;

    logic [WIDTH-1:0] tag_arr    [NUM_REQ];
    logic [6:0]       opcode_arr [NUM_REQ];
    logic [6:0]       nid_arr    [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign tag_arr[gi]    = bus.req_tag[gi*WIDTH +: WIDTH];
            assign opcode_arr[gi] = bus.req_opcode[gi*7 +: 7];
            assign nid_arr[gi]    = bus.req_nid[gi*7 +: 7];
            // Accept is combinational and only ever offered to the winner.
            assign bus.req_ready[gi] = (state_reg == IDLE) && !reset && grant_found
                                       && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Scan from the farthest candidate down so the one nearest rr_ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand     = (int'(rr_ptr_reg) + k) % NUM_REQ;
            cand_idx = ID_W'(cand);
            if (bus.req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            rr_ptr_reg      <= '0;
            id_reg          <= '0;
            lat_cnt_reg     <= '0;
            tcam_tag_reg    <= '0;
            tcam_opcode_reg <= '0;
            tcam_nid_reg    <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_flag_reg    <= '0;
            hit_cnt_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        tcam_tag_reg    <= tag_arr[grant_idx];
                        tcam_opcode_reg <= opcode_arr[grant_idx];
                        tcam_nid_reg    <= nid_arr[grant_idx];
                        id_reg          <= grant_idx;
                        lat_cnt_reg     <= LAT_W'(LOOKUP_LAT);
                        state_reg       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lat_cnt_reg == '0) begin
                        rsp_flag_reg    <= bus.tcam_flag;
                        rsp_valid_reg   <= 1'b1;
                        // Drop back to NOP so the TCAM sees no stale opcode.
                        tcam_tag_reg    <= '0;
                        tcam_opcode_reg <= '0;
                        tcam_nid_reg    <= '0;
                        if (bus.tcam_flag != 4'd0 && hit_cnt_reg != '1)
                            hit_cnt_reg <= hit_cnt_reg + 1'b1;
                        state_reg       <= RESP;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        rr_ptr_reg    <= (id_reg == ID_W'(NUM_REQ - 1)) ? '0 : id_reg + 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.tcam_tag    = tcam_tag_reg;
    assign bus.tcam_opcode = tcam_opcode_reg;
    assign bus.tcam_nid    = tcam_nid_reg;
    assign bus.rsp_valid   = rsp_valid_reg;
    assign bus.rsp_id      = id_reg;
    assign bus.rsp_flag    = rsp_flag_reg;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.hit_cnt     = hit_cnt_reg;
endmodule

// File: tb/tb_tcam_lookup_arbiter.sv
// Directed bench: instance a (LOOKUP_LAT=1, CNT_W=16), instance b (LOOKUP_LAT=3, CNT_W=4).
`timescale 1ns/1ps
module tb_tcam_lookup_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vecs = 0;
    int   errs = 0;
    logic [3:0] a_flag = 4'd0;
    logic [3:0] b_flag = 4'd0;
    logic       a_op_d = 1'b0;
    logic [2:0] b_vld_sr = 3'd0;

    always #5 clk = ~clk;

    tcam_lookup_arbiter_if #(.WIDTH(33), .NUM_REQ(4), .CNT_W(16)) a_if ();
    tcam_lookup_arbiter_if #(.WIDTH(33), .NUM_REQ(4), .CNT_W(4))  b_if ();

    tcam_lookup_arbiter #(.WIDTH(33), .NUM_REQ(4), .LOOKUP_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if.slave));
    tcam_lookup_arbiter #(.WIDTH(33), .NUM_REQ(4), .LOOKUP_LAT(3), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if.slave));

    // TCAM models: flag is valid only once the inputs have been presented
    // for the model latency; earlier it reads back as poison 4'hF.
    always @(posedge clk) begin
        a_op_d   <= (a_if.tcam_opcode != 7'd0);
        b_vld_sr <= {b_vld_sr[1:0], (b_if.tcam_opcode != 7'd0)};
    end
    assign a_if.tcam_flag = (a_op_d && a_if.tcam_opcode != 7'd0) ? a_flag : 4'hF;
    assign b_if.tcam_flag = (b_vld_sr[2] && b_if.tcam_opcode != 7'd0) ? b_flag : 4'hF;

    task automatic set_a_req(input int i, input logic [32:0] tag, input logic [6:0] op, input logic [6:0] nid);
        a_if.req_tag[i*33 +: 33] = tag;
        a_if.req_opcode[i*7 +: 7] = op;
        a_if.req_nid[i*7 +: 7] = nid;
    endtask

    task automatic set_b_req(input int i, input logic [32:0] tag, input logic [6:0] op, input logic [6:0] nid);
        b_if.req_tag[i*33 +: 33] = tag;
        b_if.req_opcode[i*7 +: 7] = op;
        b_if.req_nid[i*7 +: 7] = nid;
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_rsp_a(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (a_if.rsp_valid) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        a_if.req_valid = '0; a_if.req_tag = '0; a_if.req_opcode = '0; a_if.req_nid = '0; a_if.rsp_ready = 1'b0;
        b_if.req_valid = '0; b_if.req_tag = '0; b_if.req_opcode = '0; b_if.req_nid = '0; b_if.rsp_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vecs++;
        if ({a_if.req_ready, a_if.rsp_valid, a_if.rsp_id, a_if.rsp_flag, a_if.busy, a_if.hit_cnt,
             a_if.tcam_opcode, a_if.tcam_nid, a_if.tcam_tag} !== '0) begin
            errs++;
            $display("FAIL reset_a: ready=%b rsp_valid=%b id=%0d flag=%h busy=%b hit=%0d op=%h nid=%h tag=%h, required all 0",
                     a_if.req_ready, a_if.rsp_valid, a_if.rsp_id, a_if.rsp_flag, a_if.busy, a_if.hit_cnt,
                     a_if.tcam_opcode, a_if.tcam_nid, a_if.tcam_tag);
        end
        vecs++;
        if ({b_if.req_ready, b_if.rsp_valid, b_if.rsp_id, b_if.rsp_flag, b_if.busy, b_if.hit_cnt,
             b_if.tcam_opcode, b_if.tcam_nid, b_if.tcam_tag} !== '0) begin
            errs++;
            $display("FAIL reset_b: ready=%b rsp_valid=%b busy=%b hit=%0d, required all 0",
                     b_if.req_ready, b_if.rsp_valid, b_if.busy, b_if.hit_cnt);
        end
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_single;
        @(negedge clk);
        set_a_req(0, 33'h1_0000_00AB, 7'b0000111, 7'b0000010);
        a_if.req_valid = 4'b0001; a_if.rsp_ready = 1'b1; a_flag = 4'b0100;
        #1;
        vecs++;
        if (a_if.req_ready !== 4'b0001 || a_if.busy !== 1'b0) begin
            errs++; $display("FAIL single_accept: ready=%b busy=%b, required 0001/0", a_if.req_ready, a_if.busy);
        end
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                a_if.req_valid = 4'b0000;
                set_a_req(0, 33'h0_FFFF_FFFF, 7'h7F, 7'h7F);
            end
            #1;
            vecs++;
            if (a_if.tcam_tag !== 33'h1_0000_00AB || a_if.tcam_opcode !== 7'b0000111 ||
                a_if.tcam_nid !== 7'b0000010 || a_if.req_ready !== 4'b0000 || a_if.busy !== 1'b1 ||
                a_if.rsp_valid !== 1'b0) begin
                errs++;
                $display("FAIL single_lookup_T+%0d: tag=%h op=%h nid=%h ready=%b busy=%b rsp_valid=%b, required 1000000ab/07/02/0000/1/0",
                         c, a_if.tcam_tag, a_if.tcam_opcode, a_if.tcam_nid, a_if.req_ready, a_if.busy, a_if.rsp_valid);
            end
        end
        @(negedge clk); #1;
        vecs++;
        if (a_if.rsp_valid !== 1'b1 || a_if.rsp_id !== 2'd0 || a_if.rsp_flag !== 4'b0100 ||
            a_if.hit_cnt !== 16'd1 || a_if.tcam_opcode !== 7'd0 || a_if.tcam_tag !== 33'd0) begin
            errs++;
            $display("FAIL single_rsp: valid=%b id=%0d flag=%b hit=%0d op=%h tag=%h, required 1/0/0100/1/0/0",
                     a_if.rsp_valid, a_if.rsp_id, a_if.rsp_flag, a_if.hit_cnt, a_if.tcam_opcode, a_if.tcam_tag);
        end
        @(negedge clk); #1;
        vecs++;
        if (a_if.rsp_valid !== 1'b0 || a_if.busy !== 1'b0) begin
            errs++; $display("FAIL single_idle: rsp_valid=%b busy=%b, required 0/0", a_if.rsp_valid, a_if.busy);
        end
        $display("test_single done");
    endtask

    task automatic test_round_robin;
        int g = 0;
        int r = 0;
        pulse_reset();
        for (int i = 0; i < 4; i++) set_a_req(i, 33'(i*16 + 5), 7'(i + 1), 7'(i + 8));
        a_flag = 4'b0010; a_if.rsp_ready = 1'b1;
        for (int cyc = 0; cyc <= 20; cyc++) begin
            @(negedge clk);
            a_if.req_valid = (cyc <= 16) ? 4'b1111 : 4'b0000;
            #1;
            if (a_if.req_ready !== 4'b0000) begin
                vecs++;
                if (a_if.req_ready !== 4'(1 << (g % 4)) || cyc != g*4) begin
                    errs++;
                    $display("FAIL rr_grant%0d: ready=%b at cycle %0d, required %b at cycle %0d",
                             g, a_if.req_ready, cyc, 4'(1 << (g % 4)), g*4);
                end
                g++;
            end
            if (cyc % 4 == 1) begin
                vecs++;
                if (a_if.tcam_tag !== 33'(((cyc / 4) % 4)*16 + 5)) begin
                    errs++;
                    $display("FAIL rr_tag: tag=%h at cycle %0d, required %h", a_if.tcam_tag, cyc, 33'(((cyc / 4) % 4)*16 + 5));
                end
            end
            if (a_if.rsp_valid) begin
                vecs++;
                if (a_if.rsp_id !== 2'(r % 4) || a_if.rsp_flag !== 4'b0010) begin
                    errs++;
                    $display("FAIL rr_rsp%0d: id=%0d flag=%b, required %0d/0010", r, a_if.rsp_id, a_if.rsp_flag, r % 4);
                end
                r++;
            end
        end
        vecs++;
        if (g != 5 || r != 5 || a_if.hit_cnt !== 16'd5) begin
            errs++; $display("FAIL rr_totals: grants=%0d rsps=%0d hit=%0d, required 5/5/5", g, r, a_if.hit_cnt);
        end
        $display("test_round_robin done");
    endtask

    task automatic test_backpressure;
        bit seen;
        @(negedge clk);
        a_if.req_valid = 4'b1000; a_if.rsp_ready = 1'b0; a_flag = 4'b1001;
        #1;
        vecs++;
        if (a_if.req_ready !== 4'b1000) begin
            errs++; $display("FAIL bp_accept: ready=%b, required 1000", a_if.req_ready);
        end
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            if (cyc == 1) a_if.req_valid = 4'b0010;
            if (cyc == 8) a_if.rsp_ready = 1'b1;
            #1;
            vecs++;
            if (cyc <= 2) begin
                if (a_if.req_ready !== 4'b0000 || a_if.rsp_valid !== 1'b0) begin
                    errs++; $display("FAIL bp_lookup_c%0d: ready=%b rsp_valid=%b, required 0000/0", cyc, a_if.req_ready, a_if.rsp_valid);
                end
            end else if (cyc <= 8) begin
                if (a_if.rsp_valid !== 1'b1 || a_if.rsp_id !== 2'd3 || a_if.rsp_flag !== 4'b1001 || a_if.req_ready !== 4'b0000) begin
                    errs++;
                    $display("FAIL bp_hold_c%0d: valid=%b id=%0d flag=%b ready=%b, required 1/3/1001/0000",
                             cyc, a_if.rsp_valid, a_if.rsp_id, a_if.rsp_flag, a_if.req_ready);
                end
            end else begin
                if (a_if.req_ready !== 4'b0010 || a_if.rsp_valid !== 1'b0) begin
                    errs++; $display("FAIL bp_next_grant: ready=%b rsp_valid=%b, required 0010/0", a_if.req_ready, a_if.rsp_valid);
                end
            end
        end
        @(negedge clk);
        a_if.req_valid = 4'b0000;
        wait_rsp_a(seen);
        vecs++;
        if (!seen || a_if.rsp_id !== 2'd1 || a_if.hit_cnt !== 16'd7) begin
            errs++; $display("FAIL bp_drain: seen=%b id=%0d hit=%0d, required 1/1/7", seen, a_if.rsp_id, a_if.hit_cnt);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_miss;
        bit seen;
        @(negedge clk);
        set_a_req(0, 33'h0_0000_0042, 7'h21, 7'h03);
        a_if.req_valid = 4'b0001; a_flag = 4'b0000;
        #1;
        vecs++;
        if (a_if.req_ready !== 4'b0001) begin
            errs++; $display("FAIL miss_accept: ready=%b, required 0001", a_if.req_ready);
        end
        @(negedge clk);
        a_if.req_valid = 4'b0000;
        wait_rsp_a(seen);
        vecs++;
        if (!seen || a_if.rsp_flag !== 4'b0000 || a_if.hit_cnt !== 16'd7) begin
            errs++; $display("FAIL miss_rsp: seen=%b flag=%b hit=%0d, required 1/0000/7", seen, a_if.rsp_flag, a_if.hit_cnt);
        end
        $display("test_miss done");
    endtask

    task automatic test_reset_mid;
        bit seen;
        bit stray = 1'b0;
        @(negedge clk);
        a_if.req_valid = 4'b0100; a_flag = 4'b0101;
        #1;
        vecs++;
        if (a_if.req_ready !== 4'b0100) begin
            errs++; $display("FAIL rstmid_accept: ready=%b, required 0100", a_if.req_ready);
        end
        @(negedge clk);
        a_if.req_valid = 4'b0000; reset = 1'b1;
        #1;
        vecs++;
        if (a_if.busy !== 1'b1) begin
            errs++; $display("FAIL rstmid_in_lookup: busy=%b, required 1", a_if.busy);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vecs++;
        if ({a_if.req_ready, a_if.rsp_valid, a_if.rsp_id, a_if.rsp_flag, a_if.busy, a_if.hit_cnt,
             a_if.tcam_opcode, a_if.tcam_nid, a_if.tcam_tag} !== '0) begin
            errs++;
            $display("FAIL rstmid_outputs: rsp_valid=%b busy=%b hit=%0d op=%h tag=%h, required all 0",
                     a_if.rsp_valid, a_if.busy, a_if.hit_cnt, a_if.tcam_opcode, a_if.tcam_tag);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            if (a_if.rsp_valid !== 1'b0) stray = 1'b1;
        end
        vecs++;
        if (stray) begin
            errs++; $display("FAIL rstmid_no_rsp: rsp_valid seen=1, required never");
        end
        @(negedge clk);
        a_if.req_valid = 4'b1111;
        #1;
        vecs++;
        if (a_if.req_ready !== 4'b0001) begin
            errs++; $display("FAIL rstmid_rr_ptr: ready=%b, required 0001", a_if.req_ready);
        end
        @(negedge clk);
        a_if.req_valid = 4'b0000;
        wait_rsp_a(seen);
        vecs++;
        if (!seen || a_if.rsp_id !== 2'd0) begin
            errs++; $display("FAIL rstmid_after: seen=%b id=%0d, required 1/0", seen, a_if.rsp_id);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_lat3_saturate;
        int n = 1;
        pulse_reset();
        @(negedge clk);
        set_b_req(2, 33'h0_1234_5678, 7'h55, 7'h2A);
        set_b_req(0, 33'h1_0000_0001, 7'h11, 7'h01);
        b_if.req_valid = 4'b0100; b_if.rsp_ready = 1'b1; b_flag = 4'b0110;
        #1;
        vecs++;
        if (b_if.req_ready !== 4'b0100) begin
            errs++; $display("FAIL lat3_accept: ready=%b, required 0100", b_if.req_ready);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                b_if.req_valid = 4'b0000;
                set_b_req(2, 33'h1_FFFF_0000, 7'h01, 7'h01);
            end
            #1;
            vecs++;
            if (b_if.tcam_tag !== 33'h0_1234_5678 || b_if.tcam_opcode !== 7'h55 ||
                b_if.tcam_nid !== 7'h2A || b_if.rsp_valid !== 1'b0) begin
                errs++;
                $display("FAIL lat3_hold_T+%0d: tag=%h op=%h nid=%h rsp_valid=%b, required 012345678/55/2a/0",
                         c, b_if.tcam_tag, b_if.tcam_opcode, b_if.tcam_nid, b_if.rsp_valid);
            end
        end
        @(negedge clk); #1;
        vecs++;
        if (b_if.rsp_valid !== 1'b1 || b_if.rsp_id !== 2'd2 || b_if.rsp_flag !== 4'b0110 ||
            b_if.tcam_opcode !== 7'd0 || b_if.hit_cnt !== 4'd1) begin
            errs++;
            $display("FAIL lat3_rsp: valid=%b id=%0d flag=%b op=%h hit=%0d, required 1/2/0110/0/1",
                     b_if.rsp_valid, b_if.rsp_id, b_if.rsp_flag, b_if.tcam_opcode, b_if.hit_cnt);
        end
        b_if.req_valid = 4'b0001;
        for (int k = 0; k < 200 && n < 18; k++) begin
            @(negedge clk); #1;
            if (b_if.rsp_valid) begin
                n++;
                vecs++;
                if (b_if.hit_cnt !== 4'((n > 15) ? 15 : n) || b_if.rsp_flag !== 4'b0110) begin
                    errs++;
                    $display("FAIL sat_rsp%0d: hit=%0d flag=%b, required %0d/0110", n, b_if.hit_cnt, b_if.rsp_flag, (n > 15) ? 15 : n);
                end
            end
        end
        b_if.req_valid = 4'b0000;
        vecs++;
        if (n != 18 || b_if.hit_cnt !== 4'hF) begin
            errs++; $display("FAIL sat_total: rsps=%0d hit=%h, required 18/f", n, b_if.hit_cnt);
        end
        $display("test_lat3_saturate done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_miss();
        test_reset_mid();
        test_lat3_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000ns");
        $fatal(1);
    end
endmodule
